// File: rtl/mips_mem_pkg.sv
// Shared definitions for the Harvard instruction/data memory wrapper:
// controller states, default window bases and the word-alignment mask.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_HALT
  } mem_state_t;

  localparam logic [31:0] DEFAULT_INSTR_BASE = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_DATA_BASE  = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK         = 32'h0000_0003;

endpackage

// File: rtl/mips_mem_window.sv
// Decodes one byte address against both memory windows: alignment, per-window
// hit and per-window word index.
module mips_mem_window
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] INSTR_BASE  = DEFAULT_INSTR_BASE,
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic [31:0]      addr,
  output logic             aligned,
  output logic             instr_hit,
  output logic             data_hit,
  output logic [IDX_W-1:0] instr_index,
  output logic [IDX_W-1:0] data_index
);

  logic [29:0] instr_off;
  logic [29:0] data_off;

  // Word-granular offsets: with word-aligned bases, (A-B)>>2 equals A[31:2]-B[31:2],
  // and because the window span is a power of two the unsigned range test
  // reduces to "upper offset bits are all zero".
  assign instr_off   = addr[31:2] - INSTR_BASE[31:2];
  assign data_off    = addr[31:2] - DATA_BASE[31:2];

  assign aligned     = (addr & ALIGN_MASK) == '0;
  assign instr_hit   = ~|instr_off[29:IDX_W];
  assign data_hit    = ~|data_off[29:IDX_W];
  assign instr_index = instr_off[IDX_W-1:0];
  assign data_index  = data_off[IDX_W-1:0];

endmodule

// File: rtl/mips_harvard_mem.sv
// Harvard IMEM/DMEM pair for a MIPS core: a loader fills the arrays, then the
// CPU runs until reset or the first protocol/address fault.
module mips_harvard_mem
  import mips_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] INSTR_BASE  = DEFAULT_INSTR_BASE,
  parameter logic [31:0] DATA_BASE   = DEFAULT_DATA_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        cpu_clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        fault,
  output logic [31:0] run_cycles
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_state_t  state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] run_cycles_q;

  logic [31:0] imem [DEPTH_WORDS];
  logic [31:0] dmem [DEPTH_WORDS];

  logic             f_aligned, f_ihit, f_dhit;
  logic [IDX_W-1:0] f_iidx, f_didx;
  logic             d_aligned, d_ihit, d_dhit;
  logic [IDX_W-1:0] d_iidx, d_didx;
  logic             l_aligned, l_ihit, l_dhit;
  logic [IDX_W-1:0] l_iidx, l_didx;

  mips_mem_window #(.DEPTH_WORDS(DEPTH_WORDS), .INSTR_BASE(INSTR_BASE), .DATA_BASE(DATA_BASE))
  u_fetch_win (.addr(instr_address), .aligned(f_aligned), .instr_hit(f_ihit), .data_hit(f_dhit),
               .instr_index(f_iidx), .data_index(f_didx));

  mips_mem_window #(.DEPTH_WORDS(DEPTH_WORDS), .INSTR_BASE(INSTR_BASE), .DATA_BASE(DATA_BASE))
  u_data_win (.addr(data_address), .aligned(d_aligned), .instr_hit(d_ihit), .data_hit(d_dhit),
              .instr_index(d_iidx), .data_index(d_didx));

  mips_mem_window #(.DEPTH_WORDS(DEPTH_WORDS), .INSTR_BASE(INSTR_BASE), .DATA_BASE(DATA_BASE))
  u_load_win (.addr(load_addr), .aligned(l_aligned), .instr_hit(l_ihit), .data_hit(l_dhit),
              .instr_index(l_iidx), .data_index(l_didx));

  // Fetch only ever looks at the instruction window and the data port only at the data window.
  logic unused_window;
  assign unused_window = ^{f_dhit, f_didx, d_ihit, d_iidx};

  logic f_valid, d_valid, l_to_imem, l_to_dmem;
  logic fault_now, load_fire, load_bad, store_fire;

  assign f_valid    = f_aligned && f_ihit;
  assign d_valid    = d_aligned && d_dhit;
  // The instruction window wins when the two windows overlap.
  assign l_to_imem  = l_aligned && l_ihit;
  assign l_to_dmem  = l_aligned && !l_ihit && l_dhit;

  assign fault_now  = (state_q == ST_RUN) &&
                      (!f_valid ||
                       ((data_read || data_write) && !d_valid) ||
                       (data_read && data_write));
  assign load_fire  = (state_q == ST_LOAD) && load_valid;
  assign load_bad   = load_fire && !(l_to_imem || l_to_dmem);
  assign store_fire = (state_q == ST_RUN) && data_write && !fault_now;

  assign load_ready     = (state_q == ST_LOAD);
  assign cpu_clk_enable = (state_q == ST_RUN) && !fault_now;
  assign fault          = fault_q;
  assign run_cycles     = run_cycles_q;

  assign instr_readdata = f_valid ? imem[f_iidx] : '0;
  assign data_readdata  = (data_read && d_valid) ? dmem[d_didx] : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_LOAD: begin
        if (load_bad) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else if (load_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fault_now) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      fault_q      <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (cpu_clk_enable && (run_cycles_q != 32'hFFFF_FFFF)) begin
        run_cycles_q <= run_cycles_q + 32'd1;
      end
    end
  end

  // NOTE: the arrays have no reset branch -- contents survive reset, and reset only
  // blocks a write in flight on that edge.
  always_ff @(posedge clk) begin
    if (!reset && load_fire && l_to_imem) begin
      imem[l_iidx] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (store_fire) begin
        dmem[d_didx] <= data_writedata;
      end else if (load_fire && l_to_dmem) begin
        dmem[l_didx] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Scoreboard bench for mips_harvard_mem: expectations are queued as stimulus is
// applied and drained against the DUT outputs between clock edges.
module tb_mips_harvard_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        cpu_clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        fault;
  logic [31:0] run_cycles;

  mips_harvard_mem #(.DEPTH_WORDS(16)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_done(load_done),
    .cpu_clk_enable(cpu_clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .fault(fault), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef enum {O_LREADY, O_CEN, O_FAULT, O_RCYC, O_IRD, O_DRD} obs_e;
  typedef struct {
    string       tag;
    obs_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input obs_e sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t        e;
    logic [31:0] act;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sig)
        O_LREADY: act = 32'(load_ready);
        O_CEN:    act = 32'(cpu_clk_enable);
        O_FAULT:  act = 32'(fault);
        O_RCYC:   act = run_cycles;
        O_IRD:    act = instr_readdata;
        default:  act = data_readdata;
      endcase
      check(e.tag, act, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    load_valid     = 1'b0;
    load_addr      = '0;
    load_data      = '0;
    load_done      = 1'b0;
    data_write     = 1'b0;
    data_read      = 1'b0;
    data_address   = '0;
    data_writedata = '0;
    instr_address  = 32'hBFC0_0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet_inputs();
    reset = 1'b1;
    tick();
    do_reset();

    expect_out("rst_ready", O_LREADY, 32'd1);
    expect_out("rst_cen",   O_CEN,    32'd0);
    expect_out("rst_fault", O_FAULT,  32'd0);
    expect_out("rst_rcyc",  O_RCYC,   32'd0);
    sample();

    // Fill IMEM[0], DMEM[4], and DMEM[1] on the load_done edge.
    load_valid = 1'b1; load_addr = 32'hBFC0_0000; load_data = 32'h2402_0005;
    tick();
    load_addr = 32'h0000_0010; load_data = 32'h1111_1111;
    tick();
    load_addr = 32'h0000_0004; load_data = 32'hCAFE_F00D; load_done = 1'b1;
    expect_out("load_ready_hi", O_LREADY, 32'd1);
    expect_out("load_cen_lo",   O_CEN,    32'd0);
    sample();
    tick();
    quiet_inputs();

    // RUN: loader inputs must be ignored here.
    load_valid = 1'b1; load_addr = 32'h0000_0010; load_data = 32'h9999_9999;
    data_read = 1'b1; data_address = 32'h0000_0004;
    expect_out("run_ready_lo", O_LREADY, 32'd0);
    expect_out("run_cen",      O_CEN,    32'd1);
    expect_out("run_rcyc0",    O_RCYC,   32'd0);
    expect_out("fetch0",       O_IRD,    32'h2402_0005);
    expect_out("read_last_ld", O_DRD,    32'hCAFE_F00D);
    sample();
    tick();

    load_valid = 1'b0;
    data_address = 32'h0000_0010;
    expect_out("run_rcyc1",     O_RCYC, 32'd1);
    expect_out("loader_ignored", O_DRD, 32'h1111_1111);
    sample();
    tick();

    data_read = 1'b0; data_write = 1'b1; data_writedata = 32'hDEAD_BEEF;
    expect_out("run_rcyc2",   O_RCYC, 32'd2);
    expect_out("store_cen",   O_CEN,  32'd1);
    expect_out("store_cyc_rd", O_DRD, 32'd0);
    sample();
    tick();

    data_write = 1'b0; data_read = 1'b1;
    expect_out("run_rcyc3",  O_RCYC, 32'd3);
    expect_out("store_seen", O_DRD,  32'hDEAD_BEEF);
    sample();
    tick();

    // Read and write together: fault, no store.
    data_address = 32'h0000_0004; data_write = 1'b1; data_writedata = 32'h1234_5678;
    expect_out("rw_cen_lo", O_CEN, 32'd0);
    sample();
    tick();
    data_write = 1'b0;
    expect_out("rw_fault",    O_FAULT,  32'd1);
    expect_out("rw_halt_cen", O_CEN,    32'd0);
    expect_out("rw_halt_rdy", O_LREADY, 32'd0);
    expect_out("rw_rcyc",     O_RCYC,   32'd4);
    expect_out("rw_nostore",  O_DRD,    32'hCAFE_F00D);
    sample();
    tick();
    expect_out("halt_sticky", O_FAULT, 32'd1);
    expect_out("halt_rcyc",   O_RCYC,  32'd4);
    sample();

    // Reset keeps array contents.
    quiet_inputs();
    do_reset();
    data_read = 1'b1; data_address = 32'h0000_0010;
    expect_out("rst2_fault", O_FAULT,  32'd0);
    expect_out("rst2_ready", O_LREADY, 32'd1);
    expect_out("rst2_rcyc",  O_RCYC,   32'd0);
    expect_out("keep_dmem",  O_DRD,    32'hDEAD_BEEF);
    expect_out("keep_imem",  O_IRD,    32'h2402_0005);
    sample();

    // Misaligned data read in RUN.
    data_read = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
    data_read = 1'b1; data_address = 32'h0000_0012;
    expect_out("misal_cen", O_CEN, 32'd0);
    expect_out("misal_rd",  O_DRD, 32'd0);
    sample();
    tick();
    data_read = 1'b0;
    expect_out("misal_fault", O_FAULT,  32'd1);
    expect_out("misal_rdy",   O_LREADY, 32'd0);
    sample();

    // Loader word outside both windows, load_done on the same edge.
    quiet_inputs();
    do_reset();
    load_valid = 1'b1; load_addr = 32'h8000_0000; load_data = 32'h0000_0001; load_done = 1'b1;
    tick();
    quiet_inputs();
    expect_out("ld_bad_fault", O_FAULT,  32'd1);
    expect_out("ld_bad_rdy",   O_LREADY, 32'd0);
    expect_out("ld_bad_cen",   O_CEN,    32'd0);
    sample();

    // Fetch outside the window stalls combinationally; restored before the edge.
    do_reset();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    instr_address = 32'hBFC0_0040;
    expect_out("fetch_oob_cen", O_CEN, 32'd0);
    expect_out("fetch_oob_rd",  O_IRD, 32'd0);
    sample();
    instr_address = 32'hBFC0_0000;
    expect_out("fetch_ok_cen", O_CEN, 32'd1);
    sample();
    tick();
    tick();
    expect_out("run2_rcyc", O_RCYC, 32'd2);
    sample();

    // Reset on the same edge as a valid store.
    data_write = 1'b1; data_address = 32'h0000_0010; data_writedata = 32'h5555_5555;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_write = 1'b0; data_read = 1'b1;
    expect_out("rst_store_rcyc", O_RCYC,   32'd0);
    expect_out("rst_store_rdy",  O_LREADY, 32'd1);
    expect_out("rst_store_mem",  O_DRD,    32'hDEAD_BEEF);
    sample();

    // Misaligned loader word inside the instruction window.
    data_read = 1'b0;
    load_valid = 1'b1; load_addr = 32'hBFC0_0002; load_data = 32'hFFFF_FFFF;
    tick();
    quiet_inputs();
    expect_out("ld_misal_fault", O_FAULT, 32'd1);
    expect_out("ld_misal_imem",  O_IRD,   32'h2402_0005);
    sample();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
